mem_bus_arbiter: RTL and testbench
==================================

// Module: mem_bus_arbiter
// PURPOSE
//  Shares the single DATA_MEMORY port (ADDRESS, data, M_read, M_write) between two bus masters:
//  port 0 = processor, port 1 = secondary master (DMA / IO loader).
//  Sits between the masters and the memory in the PS top level; owns the memory strobes.
//  Serialises one transaction at a time: arbitrate, access, wait for read data, acknowledge.
//  Memory data bus is split into wdata/rdata/oe; the top level builds the tri-state.
// PARAMETERS
//  AW        8  address width
//  DW        8  data width
//  RD_LAT    1  cycles from mem_read assertion to valid mem_rdata; legal range 1..15
//  FIXED_PRI 0  0 = round-robin; 1 = port 0 always wins
// PORTS
//  clk          in   1   system clock, all logic on rising edge
//  reset        in   1   synchronous, active-high reset
//  req0/req1    in   1   transaction request; held high until ackN
//  we0/we1      in   1   1 = write, 0 = read; stable while reqN high
//  addr0/addr1  in   AW  transaction address; stable while reqN high
//  wdata0/wdata1 in  DW  write data; stable while reqN high
//  ack0/ack1    out  1   one-cycle completion pulse to the owning port
//  rdata        out  DW  read data; valid in the ack cycle, held until the next read capture
//  grant        out  1   index of the current or last owner
//  busy         out  1   high in any state other than IDLE
//  mem_addr     out  AW  memory address
//  mem_wdata    out  DW  memory write data
//  mem_data_oe  out  1   drive enable for the shared data bus; equals mem_write
//  mem_read     out  1   memory read strobe (M_read)
//  mem_write    out  1   memory write strobe (M_write)
//  mem_rdata    in   DW  memory read data
// BEHAVIOUR
//  Reset:
//   - Drives state=IDLE, all outputs 0, and last_grant=1, so port 0 has first priority.
//   - Reset mid-transaction aborts it: strobes drop at the reset edge and no ack is issued.
//  IDLE:
//   - No request: stays in IDLE.
//   - One request: that port wins.
//   - Both requesting: winner = port 0 if FIXED_PRI=1, else the port != last_grant.
//   - Winning cycle: latch addr, we, wdata and grant; next state ACCESS.
//  ACCESS (1 cycle):
//   - mem_addr and mem_wdata come from the latched values.
//   - Write: mem_write=1 and mem_data_oe=1; next state DONE.
//   - Read: mem_read=1; next state RWAIT with counter=RD_LAT-1.
//  RWAIT:
//   - mem_read stays 1 and mem_addr stays stable.
//   - counter>0: decrement and stay in RWAIT.
//   - counter==0: capture mem_rdata into rdata at this edge; next state DONE.
//  DONE (1 cycle):
//   - All strobes 0; ack[grant]=1 (exactly one ack asserted).
//   - Update last_grant=grant; next state IDLE.
//  Latency, req rise to ack:
//   - Write: ack 2 cycles after the IDLE sample cycle.
//   - Read: ack 2+RD_LAT cycles after the IDLE sample cycle.
//  Throughput:
//   - Min 3 cycles per write; 3+RD_LAT cycles per read.
//   - A req still high in the IDLE cycle after ack counts as a new transaction.
//  Arbitration and bus rules:
//   - A request arriving during busy waits; no preemption.
//   - Round-robin: with both ports continuously requesting, grants strictly alternate (no starvation).
//   - mem_read and mem_write are never both 1.
//   - The bus is idle (mem_addr=0, strobes 0) in IDLE and DONE.
//   - Outputs are registered except ack and the strobes, which are decoded from state regs only.
// TESTING
//  1. Reset, then req0 write addr=8'h10 data=8'hA5: mem_write=1 for exactly 1 cycle with mem_addr=10, mem_wdata=A5; ack0 2 cycles after sample.
//  2. RD_LAT=1, memory preloaded [10]=A5, req1 read addr=10: mem_read high 2 cycles; ack1 with rdata=A5 3 cycles after sample; ack0 stays 0.
//  3. req0 and req1 both held high for 4 transactions: grants 0,1,0,1 (round-robin); with FIXED_PRI=1 grants 0,0,0,0.
//  4. req1 raised mid port-0 read: port-1 access starts only after ack0; the port-0 strobes are unchanged.
//  5. reset asserted during RWAIT: next cycle IDLE, strobes 0, no ack; a fresh req0 completes normally.
//  6. Whole run assertions: mem_read&mem_write never 1; mem_data_oe==mem_write; ack0&ack1 never 1; every req gets exactly one ack.

Source files
------------

// File: rtl/mem_bus_arbiter.sv
// Two-master arbiter for a single data memory port: arbitrate, access, wait for read data, ack.
// Strobes and acks are decoded from state registers; address/data/grant/rdata are registered.
`timescale 1ns/1ps
module mem_bus_arbiter #(
  parameter int AW        = 8,
  parameter int DW        = 8,
  parameter int RD_LAT    = 1,
  parameter int FIXED_PRI = 0
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          req0,
  input  logic          req1,
  input  logic          we0,
  input  logic          we1,
  input  logic [AW-1:0] addr0,
  input  logic [AW-1:0] addr1,
  input  logic [DW-1:0] wdata0,
  input  logic [DW-1:0] wdata1,
  output logic          ack0,
  output logic          ack1,
  output logic [DW-1:0] rdata,
  output logic          grant,
  output logic          busy,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  output logic          mem_data_oe,
  output logic          mem_read,
  output logic          mem_write,
  input  logic [DW-1:0] mem_rdata
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACCESS = 2'd1;
  localparam logic [1:0] S_RWAIT  = 2'd2;
  localparam logic [1:0] S_DONE   = 2'd3;

  localparam logic [3:0] CNT_INIT = 4'(RD_LAT - 1);

  logic [1:0]    state_q, state_d;
  logic          grant_q, grant_d;
  logic          last_grant_q, last_grant_d;
  logic          we_q, we_d;
  logic [3:0]    cnt_q, cnt_d;
  logic [AW-1:0] mem_addr_q, mem_addr_d;
  logic [DW-1:0] mem_wdata_q, mem_wdata_d;
  logic [DW-1:0] rdata_q, rdata_d;
  logic          win_port;

  // Contention goes to port 0 under fixed priority, else to the port that did not own the bus last.
  always_comb begin
    win_port = 1'b0;
    if (req0 && req1) win_port = (FIXED_PRI != 0) ? 1'b0 : ~last_grant_q;
    else if (req1)    win_port = 1'b1;
  end

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    we_d         = we_q;
    cnt_d        = cnt_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    rdata_d      = rdata_q;
    case (state_q)
      S_IDLE: begin
        if (req0 || req1) begin
          state_d     = S_ACCESS;
          grant_d     = win_port;
          we_d        = win_port ? we1 : we0;
          mem_addr_d  = win_port ? addr1 : addr0;
          mem_wdata_d = (win_port ? we1 : we0) ? (win_port ? wdata1 : wdata0) : '0;
        end
      end
      S_ACCESS: begin
        if (we_q) begin
          state_d     = S_DONE;
          mem_addr_d  = '0;
          mem_wdata_d = '0;
        end else begin
          state_d = S_RWAIT;
          cnt_d   = CNT_INIT;
        end
      end
      S_RWAIT: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          rdata_d     = mem_rdata;
          state_d     = S_DONE;
          mem_addr_d  = '0;
          mem_wdata_d = '0;
        end
      end
      default: begin
        last_grant_d = grant_q;
        state_d      = S_IDLE;
      end
    endcase
  end

  // last_grant resets to 1 so port 0 wins the first contention.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      grant_q      <= 1'b0;
      last_grant_q <= 1'b1;
      we_q         <= 1'b0;
      cnt_q        <= 4'd0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      rdata_q      <= '0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      we_q         <= we_d;
      cnt_q        <= cnt_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      rdata_q      <= rdata_d;
    end
  end

  assign mem_write   = (state_q == S_ACCESS) && we_q;
  assign mem_read    = ((state_q == S_ACCESS) && !we_q) || (state_q == S_RWAIT);
  assign mem_data_oe = mem_write;
  assign ack0        = (state_q == S_DONE) && !grant_q;
  assign ack1        = (state_q == S_DONE) && grant_q;
  assign busy        = (state_q != S_IDLE);
  assign grant       = grant_q;
  assign mem_addr    = mem_addr_q;
  assign mem_wdata   = mem_wdata_q;
  assign rdata       = rdata_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter: round-robin instance with a memory model plus a
// fixed-priority instance exercised only under contention; acks checked by a scoreboard.
`timescale 1ns/1ps
module tb_mem_bus_arbiter;
  localparam int RD_LAT = 1;

  logic       clk = 1'b0;
  logic       reset;
  logic       req0, req1, we0, we1;
  logic [7:0] addr0, addr1, wdata0, wdata1;
  logic       ack0, ack1, grant, busy, mem_data_oe, mem_read, mem_write;
  logic [7:0] rdata, mem_addr, mem_wdata, mem_rdata;

  logic       b_en;
  logic       b_ack0, b_ack1, b_grant, b_busy, b_oe, b_rd, b_wr;
  logic [7:0] b_rdata, b_addr, b_wdata;

  always #5 clk = ~clk;

  mem_bus_arbiter #(.AW(8), .DW(8), .RD_LAT(RD_LAT), .FIXED_PRI(0)) dut (
    .clk(clk), .reset(reset), .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .ack0(ack0), .ack1(ack1), .rdata(rdata), .grant(grant), .busy(busy),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_data_oe(mem_data_oe),
    .mem_read(mem_read), .mem_write(mem_write), .mem_rdata(mem_rdata)
  );

  mem_bus_arbiter #(.AW(8), .DW(8), .RD_LAT(RD_LAT), .FIXED_PRI(1)) dut_fp (
    .clk(clk), .reset(reset), .req0(req0 & b_en), .req1(req1 & b_en), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .ack0(b_ack0), .ack1(b_ack1), .rdata(b_rdata), .grant(b_grant), .busy(b_busy),
    .mem_addr(b_addr), .mem_wdata(b_wdata), .mem_data_oe(b_oe),
    .mem_read(b_rd), .mem_write(b_wr), .mem_rdata(8'h00)
  );

  // Memory model: data is only valid exactly RD_LAT edges into a read, garbage otherwise.
  logic [7:0] mem [256];
  int         rd_cnt = 0;
  always @(posedge clk) begin
    if (mem_write) mem[mem_addr] <= mem_wdata;
    rd_cnt <= mem_read ? rd_cnt + 1 : 0;
  end
  assign mem_rdata = (rd_cnt == RD_LAT) ? mem[mem_addr] : 8'hEE;

  typedef struct {
    logic       port;
    logic       we;
    logic [7:0] data;
  } exp_t;
  exp_t sbq[$];

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    if (ack0 || ack1) begin
      if (sbq.size() == 0) chk("unexpected_ack", 32'd1, 32'd0);
      else begin
        e = sbq.pop_front();
        chk("sb_port", {31'd0, ack1}, {31'd0, e.port});
        if (!e.we) chk("sb_rdata", {24'd0, rdata}, {24'd0, e.data});
      end
    end
    chk("invariants", {26'd0, mem_read & mem_write, mem_data_oe ^ mem_write, ack0 & ack1,
                       b_rd & b_wr, b_oe ^ b_wr, b_ack0 & b_ack1}, 32'd0);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ack(input logic port, input int budget, output int lat);
    lat = 0;
    while (1) begin
      tick();
      lat++;
      if (port ? ack1 : ack0) break;
      if (lat >= budget) begin
        chk("ack_timeout", 32'd1, 32'd0);
        break;
      end
    end
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin : stim
    int lat;
    reset = 1'b1; b_en = 1'b0;
    req0 = 0; req1 = 0; we0 = 0; we1 = 0;
    addr0 = 0; addr1 = 0; wdata0 = 0; wdata1 = 0;
    foreach (mem[i]) mem[i] = 8'h00;
    mem[8'h20] = 8'h3C;
    mem[8'h30] = 8'h5A;
    repeat (2) tick();
    reset = 1'b0;

    // Reset state
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_grant", {31'd0, grant}, 32'd0);
    chk("rst_strobes", {29'd0, mem_read, mem_write, mem_data_oe}, 32'd0);
    chk("rst_acks", {30'd0, ack0, ack1}, 32'd0);
    chk("rst_bus", {8'd0, mem_addr, mem_wdata, rdata}, 32'd0);

    // 1: port 0 write
    req0 = 1; we0 = 1; addr0 = 8'h10; wdata0 = 8'hA5;
    sbq.push_back('{1'b0, 1'b1, 8'h00});
    tick();
    chk("t1_write", {31'd0, mem_write}, 32'd1);
    chk("t1_oe", {31'd0, mem_data_oe}, 32'd1);
    chk("t1_read", {31'd0, mem_read}, 32'd0);
    chk("t1_addr", {24'd0, mem_addr}, 32'h10);
    chk("t1_wdata", {24'd0, mem_wdata}, 32'hA5);
    chk("t1_busy", {31'd0, busy}, 32'd1);
    tick();
    chk("t1_ack0", {31'd0, ack0}, 32'd1);
    chk("t1_write_off", {31'd0, mem_write}, 32'd0);
    chk("t1_addr_idle", {24'd0, mem_addr}, 32'd0);
    req0 = 0;
    tick();
    chk("t1_idle", {30'd0, busy, ack0}, 32'd0);

    // 2: port 1 read of the location just written
    req1 = 1; we1 = 0; addr1 = 8'h10;
    sbq.push_back('{1'b1, 1'b0, 8'hA5});
    tick();
    chk("t2_read_a", {31'd0, mem_read}, 32'd1);
    chk("t2_grant", {31'd0, grant}, 32'd1);
    chk("t2_addr_a", {24'd0, mem_addr}, 32'h10);
    tick();
    chk("t2_read_w", {31'd0, mem_read}, 32'd1);
    chk("t2_addr_w", {24'd0, mem_addr}, 32'h10);
    chk("t2_noack", {30'd0, ack0, ack1}, 32'd0);
    tick();
    chk("t2_ack", {30'd0, ack0, ack1}, 32'd1);
    chk("t2_rdata", {24'd0, rdata}, 32'hA5);
    chk("t2_read_off", {31'd0, mem_read}, 32'd0);
    req1 = 0;
    tick();

    // 4: port 1 requests in the middle of a port 0 read
    req0 = 1; we0 = 0; addr0 = 8'h20;
    sbq.push_back('{1'b0, 1'b0, 8'h3C});
    tick();
    req1 = 1; we1 = 0; addr1 = 8'h30;
    sbq.push_back('{1'b1, 1'b0, 8'h5A});
    chk("t4_grant_a", {31'd0, grant}, 32'd0);
    chk("t4_addr_a", {24'd0, mem_addr}, 32'h20);
    tick();
    chk("t4_grant_w", {31'd0, grant}, 32'd0);
    chk("t4_addr_w", {24'd0, mem_addr}, 32'h20);
    chk("t4_read_w", {31'd0, mem_read}, 32'd1);
    tick();
    chk("t4_ack0", {30'd0, ack0, ack1}, 32'd2);
    req0 = 0;
    tick();
    chk("t4_gap", {30'd0, busy, mem_read}, 32'd0);
    wait_ack(1'b1, 10, lat);
    chk("t4_lat1", lat, 32'd3);
    req1 = 0;
    tick();

    // 3: both ports continuously requesting writes
    we0 = 1; addr0 = 8'h40; wdata0 = 8'h11;
    we1 = 1; addr1 = 8'h41; wdata1 = 8'h22;
    for (int i = 0; i < 4; i++) sbq.push_back('{1'(i % 2), 1'b1, 8'h00});
    req0 = 1; req1 = 1; b_en = 1;
    for (int i = 0; i < 4; i++) begin
      lat = 0;
      do begin
        tick();
        lat++;
      end while (!(ack0 || ack1) && lat < 6);
      chk("t3_rr_grant", {30'd0, ack0, ack1}, (i % 2) ? 32'd1 : 32'd2);
      chk("t3_fp_grant", {30'd0, b_ack0, b_ack1}, 32'd2);
    end
    req0 = 0; req1 = 0; b_en = 0;
    tick();
    chk("t3_mem40", {24'd0, mem[8'h40]}, 32'h11);
    chk("t3_mem41", {24'd0, mem[8'h41]}, 32'h22);
    chk("t3_fp_idle", {30'd0, b_busy, b_grant}, 32'd0);

    // 5: reset during RWAIT aborts the read
    req0 = 1; we0 = 0; addr0 = 8'h30;
    tick();
    tick();
    chk("t5_rwait", {31'd0, mem_read}, 32'd1);
    reset = 1;
    tick();
    chk("t5_abort", {27'd0, busy, mem_read, mem_write, ack0, ack1}, 32'd0);
    chk("t5_rdata_clr", {24'd0, rdata}, 32'd0);
    req0 = 0; reset = 0;
    tick();
    req0 = 1;
    sbq.push_back('{1'b0, 1'b0, 8'h5A});
    wait_ack(1'b0, 10, lat);
    chk("t5_lat", lat, 32'd3);
    req0 = 0;
    repeat (2) tick();

    chk("sb_empty", sbq.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
